// File: rtl/vend_pkg.sv
// vend_pkg: coin denominations, tube bit indices and payout FSM states.
// Used by the vending top FSM, the change calculator and the payout sequencer.
// No ports; constants, types and one lookup helper only.
package vend_pkg;

  localparam int AMT_W_DEF = 9;
  localparam int NUM_DENOM = 5;

  // Bit positions in tube_empty / eject vectors
  localparam int DENOM_IDX_100 = 4;
  localparam int DENOM_IDX_50  = 3;
  localparam int DENOM_IDX_25  = 2;
  localparam int DENOM_IDX_10  = 1;
  localparam int DENOM_IDX_5   = 0;

  localparam logic [8:0] DENOM_CENTS_100 = 9'd100;
  localparam logic [8:0] DENOM_CENTS_50  = 9'd50;
  localparam logic [8:0] DENOM_CENTS_25  = 9'd25;
  localparam logic [8:0] DENOM_CENTS_10  = 9'd10;
  localparam logic [8:0] DENOM_CENTS_5   = 9'd5;

  typedef enum logic [2:0] {
    PS_IDLE,
    PS_SELECT,
    PS_EJECT,
    PS_WAIT_SENSE,
    PS_FINISH
  } payout_state_t;

  // Cent value of the tube at a given bit index (0 for unused indices).
  function automatic logic [8:0] denom_cents(input logic [2:0] idx);
    case (idx)
      3'(DENOM_IDX_100): denom_cents = DENOM_CENTS_100;
      3'(DENOM_IDX_50):  denom_cents = DENOM_CENTS_50;
      3'(DENOM_IDX_25):  denom_cents = DENOM_CENTS_25;
      3'(DENOM_IDX_10):  denom_cents = DENOM_CENTS_10;
      3'(DENOM_IDX_5):   denom_cents = DENOM_CENTS_5;
      default:           denom_cents = 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/payout_timer.sv
// payout_timer: loadable down-counter, shared by the ejector pulse and sense-timeout phases.
// Latency: load takes effect next cycle; expired is combinational (count == 0), count holds at 0.
// Ports: clk, reset (async high), load/load_val (priority over dec), dec (count down), expired.
module payout_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/change_payout_sequencer.sv
// change_payout_sequencer: pays change one coin at a time, greedy largest-first, confirming each on the optic.
// Latency: start@T -> SELECT@T+1 -> eject T+2..T+1+PULSE_CYCLES; zero amount gives done@T+2.
// Backpressure: start is accepted only in IDLE; starts while busy are dropped, not queued.
// Ports: clk, reset (async high); start/change_amount request; tube_empty[4:0] ($1,50,25,10,5c);
//   coin_sense optic; eject[4:0] one-hot solenoids; busy, done, fault, remaining, paid_amount status.
module change_payout_sequencer
  import vend_pkg::*;
#(
  parameter int AMT_W          = AMT_W_DEF,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amount,
  input  logic [4:0]       tube_empty,
  input  logic             coin_sense,
  output logic [4:0]       eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [AMT_W-1:0] paid_amount
);

  localparam int TMR_W = 16;
  // Timer is loaded with N-1 so that the phase lasts exactly N cycles including the expiry cycle.
  localparam logic [TMR_W-1:0] PULSE_LOAD   = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  payout_state_t          state_q, state_d;
  logic [2:0]             k_q, k_d;
  logic [NUM_DENOM-1:0]   skip_q, skip_d;
  logic [AMT_W-1:0]       rem_q, rem_d;
  logic [AMT_W-1:0]       paid_q, paid_d;
  logic                   fault_q, fault_d;
  logic                   sensed_q, sensed_d;
  logic                   sense_prev_q;

  logic                   sense_rise;
  logic                   sel_found;
  logic [2:0]             sel_idx;
  logic [AMT_W-1:0]       k_val;
  logic                   tmr_load, tmr_dec, tmr_expired;
  logic [TMR_W-1:0]       tmr_val;

  assign sense_rise = coin_sense & ~sense_prev_q;
  assign k_val      = AMT_W'(denom_cents(k_q));

  // Ascending scan: the last qualifying index wins, i.e. the largest usable coin.
  // Requiring value <= remaining keeps the later subtraction from underflowing.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (!tube_empty[i] && !skip_q[i] &&
          (AMT_W'(denom_cents(3'(i))) <= rem_q)) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    skip_d   = skip_q;
    rem_d    = rem_q;
    paid_d   = paid_q;
    fault_d  = fault_q;
    sensed_d = sensed_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      PS_IDLE: begin
        if (start) begin
          rem_d   = change_amount;
          paid_d  = '0;
          fault_d = 1'b0;
          skip_d  = '0;
          state_d = PS_SELECT;
        end
      end
      PS_SELECT: begin
        if (rem_q == '0) begin
          state_d = PS_FINISH;
        end else if (!sel_found) begin
          fault_d = 1'b1;
          state_d = PS_FINISH;
        end else begin
          k_d      = sel_idx;
          sensed_d = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
          state_d  = PS_EJECT;
        end
      end
      PS_EJECT: begin
        // A fast coin can reach the optic while the solenoid is still energised.
        if (sense_rise) begin
          sensed_d = 1'b1;
        end
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LOAD;
          state_d  = PS_WAIT_SENSE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      PS_WAIT_SENSE: begin
        // Sense is checked before expiry so a coin on the last timeout cycle still counts.
        if (sensed_q || sense_rise) begin
          rem_d   = rem_q - k_val;
          paid_d  = paid_q + k_val;
          state_d = PS_SELECT;
        end else if (tmr_expired) begin
          skip_d[k_q] = 1'b1;
          state_d     = PS_SELECT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      PS_FINISH: begin
        state_d = PS_IDLE;
      end
      default: begin
        state_d = PS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PS_IDLE;
      k_q          <= '0;
      skip_q       <= '0;
      rem_q        <= '0;
      paid_q       <= '0;
      fault_q      <= 1'b0;
      sensed_q     <= 1'b0;
      sense_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      skip_q       <= skip_d;
      rem_q        <= rem_d;
      paid_q       <= paid_d;
      fault_q      <= fault_d;
      sensed_q     <= sensed_d;
      sense_prev_q <= coin_sense;
    end
  end

  payout_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .expired  (tmr_expired)
  );

  // Outputs decode straight from state so the async reset drops the solenoid immediately.
  always_comb begin
    eject = '0;
    if (state_q == PS_EJECT) begin
      eject[k_q] = 1'b1;
    end
  end

  assign busy        = (state_q != PS_IDLE);
  assign done        = (state_q == PS_FINISH);
  assign fault       = fault_q;
  assign remaining   = rem_q;
  assign paid_amount = paid_q;

endmodule

// File: tb/tb_change_payout_sequencer.sv
// Bench for change_payout_sequencer: directed steps, scoreboard of expected ejects and done results.
// Latency: expectations are pushed at start; ejects/done are popped as the DUT produces them.
// A sense responder pulses coin_sense a fixed number of cycles after each ejector pulse ends.
module tb_change_payout_sequencer;

  localparam int AMT_W = 9;
  localparam int PULSE = 4;
  localparam int TMO   = 50;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [AMT_W-1:0] change_amount;
  logic [4:0]       tube_empty;
  logic             coin_sense;
  logic [4:0]       eject;
  logic             busy, done, fault;
  logic [AMT_W-1:0] remaining, paid_amount;

  always #5 clk = ~clk;

  change_payout_sequencer #(
    .AMT_W          (AMT_W),
    .PULSE_CYCLES   (PULSE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .change_amount (change_amount),
    .tube_empty    (tube_empty),
    .coin_sense    (coin_sense),
    .eject         (eject),
    .busy          (busy),
    .done          (done),
    .fault         (fault),
    .remaining     (remaining),
    .paid_amount   (paid_amount)
  );

  typedef struct packed {
    logic [AMT_W-1:0] paid;
    logic [AMT_W-1:0] rem;
    logic             flt;
  } res_t;

  logic [4:0] exp_ej_q[$];
  res_t       exp_res_q[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [4:0] prev_eject = '0;
  int         ej_len = 0;
  int         gap = 0;
  bit         gap_valid = 1'b0;
  bit         chk_gap = 1'b0;
  bit         done_seen = 1'b0;
  int         sense_at = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference greedy payout: every coin confirmed (pays=1) or every coin jams (pays=0).
  task automatic expect_payout(input int amt, input logic [4:0] empty, input bit pays);
    int         rem;
    int         paid;
    int         k;
    bit         found;
    logic [4:0] skip;
    int         vals[5];
    res_t       r;
    vals = '{5, 10, 25, 50, 100};
    rem  = amt;
    paid = 0;
    skip = '0;
    k    = 0;
    while (1) begin
      found = 1'b0;
      for (int i = 4; i >= 0; i--) begin
        if (!found && !empty[i] && !skip[i] && vals[i] <= rem) begin
          found = 1'b1;
          k     = i;
        end
      end
      if (!found) break;
      exp_ej_q.push_back(5'(1 << k));
      if (pays) begin
        rem  = rem - vals[k];
        paid = paid + vals[k];
      end else begin
        skip[k] = 1'b1;
      end
    end
    r.paid = AMT_W'(paid);
    r.rem  = AMT_W'(rem);
    r.flt  = (rem != 0);
    exp_res_q.push_back(r);
  endtask

  // One clock: sample outputs 1 time unit after the edge, score them, then drive coin_sense.
  task automatic tick();
    res_t r;
    @(posedge clk);
    #1;
    if (eject != '0) begin
      if (prev_eject == '0) begin
        // Gap between pulses of jammed coins: TMO wait cycles plus one SELECT cycle.
        if (chk_gap && gap_valid) chk("wait_gap", gap, TMO + 1);
        if (exp_ej_q.size() == 0) chk("eject_unexpected", eject, 0);
        else chk("eject_denom", eject, exp_ej_q.pop_front());
        ej_len    = 1;
        gap_valid = 1'b0;
      end else begin
        ej_len++;
      end
    end else begin
      if (prev_eject != '0) begin
        chk("pulse_len", ej_len, PULSE);
        gap       = 1;
        gap_valid = 1'b1;
      end else begin
        gap++;
      end
    end
    if (done === 1'b1) begin
      done_seen = 1'b1;
      chk("busy_at_done", busy, 1);
      // After the last jam: TMO wait cycles, SELECT, then the FINISH cycle itself.
      if (chk_gap && gap_valid) chk("final_wait", gap, TMO + 2);
      if (exp_res_q.size() == 0) begin
        chk("done_unexpected", done, 0);
      end else begin
        r = exp_res_q.pop_front();
        chk("paid", paid_amount, r.paid);
        chk("remaining", remaining, r.rem);
        chk("fault", fault, r.flt);
      end
      gap_valid = 1'b0;
    end
    prev_eject = eject;
    coin_sense = (sense_at > 0) && gap_valid && (eject == '0) && (gap == sense_at);
  endtask

  task automatic do_start(input int amt);
    change_amount = AMT_W'(amt);
    start         = 1'b1;
    done_seen     = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) tick();
    chk("done_within_budget", done_seen, 1);
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    change_amount = '0;
    tube_empty    = '0;
    coin_sense    = 1'b0;
    tick();
    tick();
    chk("rst_eject", eject, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_paid", paid_amount, 0);
    reset = 1'b0;
    tick();

    // 185c, all tubes full, coin seen 3 cycles after each pulse
    sense_at = 3;
    expect_payout(185, 5'b00000, 1'b1);
    do_start(185);
    chk("busy_after_start", busy, 1);
    chk("no_eject_in_select", eject, 0);
    tick();
    chk("first_eject_latency", eject, 5'b10000);
    wait_done(400);
    chk("busy_dropped", busy, 0);

    // 100c with the $1 tube empty
    tube_empty = 5'b10000;
    expect_payout(100, 5'b10000, 1'b1);
    do_start(100);
    wait_done(400);
    tube_empty = 5'b00000;

    // 25c, optic never fires: every usable tube jams once
    sense_at = 0;
    chk_gap  = 1'b1;
    expect_payout(25, 5'b00000, 1'b0);
    do_start(25);
    wait_done(600);
    chk_gap = 1'b0;
    tick();
    chk("fault_held", fault, 1);

    // zero amount finishes two cycles after start
    expect_payout(0, 5'b00000, 1'b1);
    do_start(0);
    chk("zero_no_done_yet", done, 0);
    tick();
    chk("zero_done_at_t2", done, 1);
    wait_done(10);

    // 7c: one nickel, 2c residue left owed
    sense_at = 3;
    expect_payout(7, 5'b00000, 1'b1);
    do_start(7);
    chk("fault_cleared_on_start", fault, 0);
    wait_done(200);

    // second start mid-payout is dropped
    expect_payout(60, 5'b00000, 1'b1);
    do_start(60);
    tick();
    tick();
    tick();
    change_amount = AMT_W'(200);
    start         = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400);

    // optic glitch while idle changes nothing
    coin_sense = 1'b1;
    tick();
    tick();
    tick();
    chk("idle_glitch_paid", paid_amount, 60);
    chk("idle_glitch_busy", busy, 0);

    // coin seen on the very last timeout cycle still counts as paid
    sense_at = TMO;
    expect_payout(25, 5'b00000, 1'b1);
    do_start(25);
    wait_done(200);

    // reset in the middle of an ejector pulse
    sense_at = 3;
    exp_ej_q.push_back(5'b10000);
    do_start(100);
    for (int i = 0; i < 10 && eject == '0; i++) tick();
    tick();
    chk("eject_before_reset", eject, 5'b10000);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_eject", eject, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_fault", fault, 0);
    chk("arst_remaining", remaining, 0);
    chk("arst_paid", paid_amount, 0);
    exp_ej_q.delete();
    exp_res_q.delete();
    prev_eject = '0;
    gap_valid  = 1'b0;
    ej_len     = 0;
    tick();
    reset = 1'b0;
    tick();
    expect_payout(35, 5'b00000, 1'b1);
    do_start(35);
    wait_done(300);

    chk("eject_queue_drained", exp_ej_q.size(), 0);
    chk("result_queue_drained", exp_res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
